s2_wr_arbiter: RTL
==================

Name: s2_wr_arbiter

Overview:
- Write-path arbiter and sequencer for the slave 2 (S2) port of the 4-master/7-slave AXI interconnect.
- Shares the single S2 write path (AW, W and B channels) among NUM_MASTERS requesters using round-robin arbitration.
- Holds each grant from address acceptance through the write response, so one write is outstanding at S2 at a time.
- Drives the one-hot grant and per-channel enables used by the external mux logic. Checks the W beat count against the latched AWLEN.

Parameters:
- NUM_MASTERS, 4, number of requesting masters.
- LEN_W, 4, AWLEN width (bursts of 1-16 beats).
- TIMEOUT_CYCLES, 256, watchdog limit; used only with S2_ARB_TIMEOUT_EN.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous, active-high reset.
- req_awvalid  in  NUM_MASTERS  per-master AWVALID, already address-decoded to S2.
- s_awvalid  in  1  muxed S2_AWVALID (granted master).
- s_awready  in  1  S2_AWREADY.
- s_awlen  in  LEN_W  muxed S2_AWLEN.
- s_wvalid  in  1  muxed S2_WVALID.
- s_wready  in  1  S2_WREADY.
- s_wlast  in  1  muxed S2_WLAST.
- s_bvalid  in  1  S2_BVALID.
- s_bready  in  1  muxed S2_BREADY (granted master).
- grant  out  NUM_MASTERS  one-hot grant.
- grant_idx  out  $clog2(NUM_MASTERS)  binary index of the granted master.
- aw_en  out  1  AW mux enable.
- w_en  out  1  W mux enable.
- b_en  out  1  B route enable.
- busy  out  1  high in any state other than IDLE.
- len_err  out  1  sticky W-length mismatch flag.
- timeout_err  out  1  one-cycle watchdog pulse (feature only).

Behaviour:
- Reset: ARESET is asynchronous and active-high; the clock is ACLK. On reset:
  - state=IDLE
  - grant=0, grant_idx=0
  - aw_en=w_en=b_en=busy=0
  - len_err=0, timeout_err=0
  - last_idx=NUM_MASTERS-1, so master 0 wins first
  - beat_cnt=0
- Reset asserted mid-burst aborts immediately to the reset values above; no partial state survives.
- FSM states: IDLE, AW, W, B.
- IDLE: if req_awvalid != 0, select the first set bit searching from last_idx+1 upward, wrapping modulo NUM_MASTERS. Register grant and grant_idx, then go to AW. Latency is one cycle from request to aw_en=1.
- AW: aw_en=1.
  - On s_awvalid & s_awready: latch awlen_q=s_awlen, clear beat_cnt, go to W.
  - Deassertion of req_awvalid by the granted master is ignored; the arbiter stays in AW.
- W: w_en=1. Each s_wvalid & s_wready increments beat_cnt; beat_cnt is LEN_W+1 bits wide and saturates.
  - On a handshake with s_wlast=1: if beat_cnt (pre-increment) != awlen_q, set len_err. Then go to B.
  - A beat count above awlen_q without WLAST sets len_err; the arbiter stays in W until WLAST arrives.
- B: b_en=1. On s_bvalid & s_bready: last_idx=grant_idx, grant=0, go to IDLE.
- Re-arbitration: there is no back-to-back bypass; IDLE always costs one cycle between grants.
- grant and grant_idx are stable from entry to AW until exit from B.
- Requests that change while the arbiter is non-IDLE have no effect until the next IDLE.
- Exactly one of aw_en, w_en, b_en is high whenever busy=1.
- An early W beat from a non-granted master is not visible: the external mux gates it with w_en.

Optional Feature:
- Macro S2_ARB_TIMEOUT_EN.
- When defined: a 16-bit watchdog clears on every state transition and on every W handshake, and increments in AW, W and B. On reaching TIMEOUT_CYCLES it pulses timeout_err for one cycle, forces IDLE, clears grant, and sets last_idx=grant_idx.
- When undefined: there is no counter, timeout_err is tied to 0, and a stalled master holds S2 indefinitely.

Test Plan:
- Reset, then req_awvalid=4'b0001, AWLEN=3, 4 W beats with WLAST on the 4th, one B beat -> grant=0001 one cycle after the request, states AW/W/B in order, len_err=0, busy falls the cycle after the B handshake.
- req_awvalid=4'b1111 held across 4 single-beat writes -> grant sequence 0001, 0010, 0100, 1000, with one IDLE cycle between grants.
- Master 2 granted; master 0 and master 3 request mid-burst -> grant stays 0100 until the B handshake, then goes to 1000 (round-robin after index 2).
- AWLEN=3 with WLAST on the 2nd beat -> len_err=1 after that beat, FSM moves to B, len_err stays set until ARESET.
- ARESET pulsed while in W with beat_cnt=2 -> all outputs zero immediately, asynchronously; after release, req_awvalid=4'b0001 gives grant=0001 again.
- With S2_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=256: AW is granted but s_awready is held low -> timeout_err pulses in the 256th stalled cycle, FSM returns to IDLE, and the next pending master is granted.

Source files
------------

// File: rtl/s2_wr_arbiter.sv
// S2 write-path round-robin arbiter: holds one grant from AW acceptance through B.
// Optional watchdog enabled by defining S2_ARB_TIMEOUT_EN.
module s2_wr_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int LEN_W          = 4,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int IDX_W         = $clog2(NUM_MASTERS)
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [NUM_MASTERS-1:0] req_awvalid,
  input  logic                   s_awvalid,
  input  logic                   s_awready,
  input  logic [LEN_W-1:0]       s_awlen,
  input  logic                   s_wvalid,
  input  logic                   s_wready,
  input  logic                   s_wlast,
  input  logic                   s_bvalid,
  input  logic                   s_bready,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   aw_en,
  output logic                   w_en,
  output logic                   b_en,
  output logic                   busy,
  output logic                   len_err,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       last_idx;
  logic [IDX_W-1:0]       pick_idx;
  logic [NUM_MASTERS-1:0] hi_req;
  logic [LEN_W-1:0]       awlen_q;
  logic [LEN_W:0]         beat_cnt;
  logic                   aw_hs, w_hs, b_hs;
  logic                   timeout_hit;

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign b_hs  = s_bvalid & s_bready;

  // Requests above last_idx take priority; otherwise wrap to the lowest index.
  always_comb begin
    hi_req   = '0;
    pick_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++)
      hi_req[k] = req_awvalid[k] && (k > int'(last_idx));
    for (int k = NUM_MASTERS - 1; k >= 0; k--)
      if (req_awvalid[k]) pick_idx = IDX_W'(k);
    for (int k = NUM_MASTERS - 1; k >= 0; k--)
      if (hi_req[k]) pick_idx = IDX_W'(k);
  end

  // NOTE: state_nxt is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_awvalid)     state_nxt = AW;
      AW:      if (aw_hs)            state_nxt = W;
      W:       if (w_hs && s_wlast)  state_nxt = B;
      B:       if (b_hs)             state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
    if (timeout_hit) state_nxt = IDLE;
  end

  assign aw_en = (state == AW);
  assign w_en  = (state == W);
  assign b_en  = (state == B);
  assign busy  = (state != IDLE);

  // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      last_idx  <= IDX_W'(NUM_MASTERS - 1);
      awlen_q   <= '0;
      beat_cnt  <= '0;
      len_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (|req_awvalid) begin
          grant     <= NUM_MASTERS'(1) << pick_idx;
          grant_idx <= pick_idx;
        end
        AW: if (aw_hs) begin
          awlen_q  <= s_awlen;
          beat_cnt <= '0;
        end
        W: if (w_hs) begin
          if (!(&beat_cnt)) beat_cnt <= beat_cnt + 1'b1;
          // A final beat must land exactly on awlen; any non-final beat at or past it overruns.
          if (s_wlast ? (beat_cnt != {1'b0, awlen_q}) : (beat_cnt >= {1'b0, awlen_q}))
            len_err <= 1'b1;
        end
        B: if (b_hs) begin
          last_idx <= grant_idx;
          grant    <= '0;
        end
        default: ;
      endcase
      if (timeout_hit) begin
        last_idx <= grant_idx;
        grant    <= '0;
      end
    end
  end

`ifdef S2_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;

  assign timeout_hit = (state != IDLE) && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_hit;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)                                     wd_cnt <= '0;
    else if ((state_nxt != state) || (state == W && w_hs)) wd_cnt <= '0;
    else if (state != IDLE)                         wd_cnt <= wd_cnt + 16'd1;
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign timeout_err        = 1'b0;
`endif

endmodule
